// File: rtl/m_switch_request_unit.sv
// -----------------------------------------------------------------------------
// m_switch_request_unit
//
// Input-port side of switch allocation. There is one instance per router input
// port. The unit:
//   - buffers incoming flits in a small FIFO,
//   - decodes the route carried by head and single flits,
//   - drives this port's enable and request lines into the switch allocator,
//   - forwards a flit to the crossbar on every cycle that is granted,
//   - keeps one downstream credit counter per output channel,
//   - holds its output channel for a whole packet (wormhole switching).
//
// Flit format:
//   flit[FLIT_W-1:FLIT_W-2]  type: 01 head, 00 body, 10 tail, 11 single
//   flit[FLIT_W-3:FLIT_W-5]  route (output index 0..4), in head/single only
//
// Ports:
//   CLK, RST     clock (rising edge) and synchronous active-high reset
//   in_valid     upstream flit valid
//   in_flit      upstream flit
//   in_ready     FIFO not full; a flit transfers when in_valid & in_ready
//   enable       a request is presented to the allocator this cycle
//   request      one-hot output channel that is requested
//   grant        allocator grant for this input port
//   out_valid    one-cycle strobe: out_flit/out_port hold a new flit
//   out_flit     flit to the crossbar (holds its value between strobes)
//   out_port     one-hot crossbar select for out_flit
//   credit_in    per-output credit return; one pulse frees one slot
//   err_route    one-cycle pulse: a head flit was dropped
// -----------------------------------------------------------------------------
module m_switch_request_unit #(
   parameter int P_ROUTER_ID  = 0,
   parameter int P_CHANNEL_ID = 0,
   parameter int FLIT_W       = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int CREDITS      = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   input  logic [FLIT_W-1:0] in_flit,
   output logic              in_ready,
   output logic              enable,
   output logic [4:0]        request,
   input  logic              grant,
   output logic              out_valid,
   output logic [FLIT_W-1:0] out_flit,
   output logic [4:0]        out_port,
   input  logic [4:0]        credit_in,
   output logic              err_route
);

   localparam int CH = 5;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam int CW = $clog2(CREDITS + 1);

   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   // The router and channel ids only tag the instance; they are checked here
   // so that a mis-numbered instance is caught at elaboration.
   if (P_ROUTER_ID < 0 || P_CHANNEL_ID < 0 || P_CHANNEL_ID > 4 ||
       FLIT_W < 6 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CREDITS < 1) begin : g_param_check
      $error("m_switch_request_unit: illegal parameter set");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_XFER
   } state_t;

   state_t            state;
   logic [2:0]        out_sel;

   // ---------------------------------------------------------------------------
   // Input FIFO
   // ---------------------------------------------------------------------------
   logic [FLIT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [NW-1:0]     count;

   logic              empty;
   logic              full;
   logic              push;
   logic              pop;

   logic [FLIT_W-1:0] front;
   logic [1:0]        front_type;
   logic [2:0]        front_route;
   logic              front_is_head;
   logic              route_bad;

   assign empty         = (count == '0);
   assign full          = (count == NW'(FIFO_DEPTH));
   assign in_ready      = ~full;
   assign push          = in_valid & ~full;

   assign front         = mem[rd_ptr];
   assign front_type    = front[FLIT_W-1 -: 2];
   assign front_route   = front[FLIT_W-3 -: 3];
   // Head and single both carry a route and both have type bit 0 set.
   assign front_is_head = front_type[0];
   assign route_bad     = (front_route > 3'd4);

   // Storage needs no reset: reset empties the FIFO through the pointers.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= in_flit;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Credits and request generation
   // ---------------------------------------------------------------------------
   logic [CW-1:0]     credit [CH];
   logic [CH-1:0]     credit_avail;
   logic [CH-1:0]     sel_oh;
   logic [CH-1:0]     credit_dec;
   logic              credit_ok;
   logic              fire;
   logic              drop;
   logic              err_now;

   always_comb begin
      credit_avail = '0;
      for (int i = 0; i < CH; i++) begin
         credit_avail[i] = (credit[i] != '0);
      end
   end

   assign sel_oh    = 5'b00001 << out_sel;
   assign credit_ok = |(credit_avail & sel_oh);

   // A head at the front mid-packet is about to be dropped, so it must never
   // be offered to the allocator.
   assign enable  = ~empty & credit_ok &
                    ((state == S_REQ) | ((state == S_XFER) & ~front_is_head));
   assign request = enable ? sel_oh : '0;

   // Grant is only honoured while enable is asserted.
   assign fire = enable & grant;

   // Flits discarded without crossing the switch: stray body/tail and
   // bad-route heads while idle, and any head arriving mid-packet.
   assign drop = ~empty &
                 (((state == S_IDLE) & (~front_is_head | route_bad)) |
                  ((state == S_XFER) & front_is_head));

   assign err_now = ~empty & front_is_head &
                    (((state == S_IDLE) & route_bad) | (state == S_XFER));

   assign pop        = fire | drop;
   assign credit_dec = fire ? sel_oh : '0;

   // Simultaneous return and consumption cancel; returns saturate at CREDITS.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < CH; i++) begin
            credit[i] <= CW'(CREDITS);
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (credit_in[i] && !credit_dec[i]) begin
               if (credit[i] != CW'(CREDITS)) begin
                  credit[i] <= credit[i] + 1'b1;
               end
            end else if (credit_dec[i] && !credit_in[i]) begin
               credit[i] <= credit[i] - 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Packet FSM and registered crossbar outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         out_sel   <= '0;
         out_valid <= 1'b0;
         out_flit  <= '0;
         out_port  <= '0;
         err_route <= 1'b0;
      end else begin
         out_valid <= fire;
         err_route <= err_now;
         if (fire) begin
            out_flit <= front;
            out_port <= sel_oh;
         end

         unique case (state)
            S_IDLE: begin
               // Latch the route but leave the head in the FIFO; it is popped
               // only when the allocator grants it.
               if (!empty && front_is_head && !route_bad) begin
                  out_sel <= front_route;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (fire) begin
                  state <= (front_type == T_SINGLE) ? S_IDLE : S_XFER;
               end
            end
            S_XFER: begin
               if (fire && front_type == T_TAIL) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_switch_request_unit.sv
// -----------------------------------------------------------------------------
// tb_m_switch_request_unit
//
// Randomized bench for m_switch_request_unit. An upstream packet generator,
// random grants and random credit returns drive the unit; a packet-level
// reference model (flit queue, locked output, credit array) predicts every
// output each cycle. Mid-run resets are taken with the FIFO full.
// -----------------------------------------------------------------------------
module tb_m_switch_request_unit;

   localparam int FLIT_W = 16;
   localparam int DEPTH  = 4;
   localparam int CRED   = 3;
   localparam int CYCLES = 4500;

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   logic              CLK = 1'b0;
   logic              RST;
   logic              in_valid;
   logic [FLIT_W-1:0] in_flit;
   logic              in_ready;
   logic              enable;
   logic [4:0]        request;
   logic              grant;
   logic              out_valid;
   logic [FLIT_W-1:0] out_flit;
   logic [4:0]        out_port;
   logic [4:0]        credit_in;
   logic              err_route;

   m_switch_request_unit #(
      .P_ROUTER_ID  (0),
      .P_CHANNEL_ID (1),
      .FLIT_W       (FLIT_W),
      .FIFO_DEPTH   (DEPTH),
      .CREDITS      (CRED)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_flit   (in_flit),
      .in_ready  (in_ready),
      .enable    (enable),
      .request   (request),
      .grant     (grant),
      .out_valid (out_valid),
      .out_flit  (out_flit),
      .out_port  (out_port),
      .credit_in (credit_in),
      .err_route (err_route)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   //   mq      flits buffered in the port
   //   cred    downstream slots per output
   //   lock    output the current packet is bound to, -1 when none
   //   sent    head of the current packet has already crossed the switch
   // ---------------------------------------------------------------------------
   logic [FLIT_W-1:0] mq [$];
   int                cred [5];
   int                lock;
   bit                sent;
   bit                m_ov;
   bit                m_err;
   logic [FLIT_W-1:0] m_of;
   logic [4:0]        m_op;

   function automatic bit is_head(input logic [FLIT_W-1:0] f);
      logic [1:0] t;
      t = f[FLIT_W-1 -: 2];
      return (t == T_HEAD) || (t == T_SINGLE);
   endfunction

   function automatic bit m_enable();
      if (lock < 0 || mq.size() == 0 || cred[lock] == 0) return 1'b0;
      if (sent && is_head(mq[0])) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_reset();
      mq.delete();
      foreach (cred[i]) cred[i] = CRED;
      lock  = -1;
      sent  = 1'b0;
      m_ov  = 1'b0;
      m_err = 1'b0;
      m_of  = '0;
      m_op  = '0;
   endtask

   task automatic m_step(input bit iv, input logic [FLIT_W-1:0] fl,
                         input bit g, input logic [4:0] ci);
      bit                take;
      bit                pop;
      bit                en;
      int                used;
      int                r;
      logic [1:0]        t;
      logic [FLIT_W-1:0] f;
      take  = iv && (mq.size() < DEPTH);
      pop   = 1'b0;
      used  = -1;
      en    = m_enable();
      m_ov  = 1'b0;
      m_err = 1'b0;
      if (mq.size() > 0) begin
         f = mq[0];
         t = f[FLIT_W-1 -: 2];
         r = int'(f[FLIT_W-3 -: 3]);
         if (lock < 0) begin
            if (!is_head(f)) pop = 1'b1;
            else if (r > 4) begin pop = 1'b1; m_err = 1'b1; end
            else begin lock = r; sent = 1'b0; end
         end else if (sent && is_head(f)) begin
            pop   = 1'b1;
            m_err = 1'b1;
         end else if (en && g) begin
            pop  = 1'b1;
            m_ov = 1'b1;
            m_of = f;
            m_op = 5'(1 << lock);
            used = lock;
            if (t == T_SINGLE || t == T_TAIL) lock = -1;
            else sent = 1'b1;
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (ci[i] && used != i) cred[i] = (cred[i] < CRED) ? cred[i] + 1 : CRED;
         else if (!ci[i] && used == i) cred[i] = cred[i] - 1;
      end
      if (pop) void'(mq.pop_front());
      if (take) mq.push_back(fl);
   endtask

   task automatic compare();
      bit en;
      en = m_enable();
      chk("in_ready",  in_ready,  mq.size() < DEPTH);
      chk("enable",    enable,    en);
      chk("request",   request,   en ? 5'(1 << lock) : 5'b0);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("out_flit", out_flit, m_of);
         chk("out_port", out_port, m_op);
      end
      chk("err_route", err_route, m_err);
   endtask

   // ---------------------------------------------------------------------------
   // Upstream packet generator: 1..4 flits, about 1 in 8 heads misrouted.
   // ---------------------------------------------------------------------------
   logic [FLIT_W-1:0] pend [$];

   task automatic gen_packet();
      int         len;
      logic [2:0] route;
      logic [1:0] t;
      len   = int'($urandom_range(1, 4));
      route = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                          : 3'($urandom_range(0, 4));
      for (int k = 0; k < len; k++) begin
         if (len == 1)       t = T_SINGLE;
         else if (k == 0)    t = T_HEAD;
         else if (k == len-1) t = T_TAIL;
         else                t = T_BODY;
         // Non-head flits carry a random route field, which must be ignored.
         pend.push_back({t, (k == 0) ? route : 3'($urandom_range(0, 7)),
                         (FLIT_W-5)'($urandom)});
      end
   endtask

   initial begin
      int  phase;
      int  gp;
      int  cp;
      int  vp;
      bit  stall;
      RST       = 1'b1;
      in_valid  = 1'b0;
      in_flit   = '0;
      grant     = 1'b0;
      credit_in = '0;
      m_reset();
      @(negedge CLK);
      RST = 1'b0;

      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         compare();

         // Phases: free-flowing, back-pressured, credit-starved.
         phase = (cyc / 300) % 3;
         gp    = (phase == 0) ? 80 : (phase == 1) ? 20 : 90;
         cp    = (phase == 0) ? 30 : (phase == 1) ? 15 : 4;
         vp    = 70;
         // Every 1000 cycles: stall the allocator long enough to fill the
         // FIFO, then reset mid-packet.
         stall = (cyc % 1000) >= 990;
         if (stall) begin gp = 0; vp = 100; end

         if (pend.size() == 0) gen_packet();
         RST       = ((cyc % 1000) == 999);
         in_valid  = ($urandom_range(0, 99) < vp);
         in_flit   = in_valid ? pend[0] : FLIT_W'($urandom);
         grant     = ($urandom_range(0, 99) < gp);
         for (int i = 0; i < 5; i++) credit_in[i] = ($urandom_range(0, 99) < cp);

         if (RST) begin
            m_reset();
         end else begin
            if (in_valid && mq.size() < DEPTH) void'(pend.pop_front());
            m_step(in_valid, in_flit, grant, credit_in);
         end
         @(negedge CLK);
      end

      compare();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
